// File: rtl/vend_pkg.sv
// vend_pkg: shared state encoding and coin codes for the vending sequencer.
package vend_pkg;
  typedef enum logic [1:0] {COLLECT, VEND, REFUND} vend_state_t;
  localparam logic [1:0] COIN_5 = 2'b01;
  localparam logic [1:0] COIN_10 = 2'b10;
endpackage

// File: rtl/vend_if.sv
// vend_if: coin, keypad, motor and ejector handshakes of the vending sequencer.
interface vend_if #(parameter int CREDIT_W = 4);
  logic coin_valid;
  logic [1:0] coin;
  logic coin_ready;
  logic coin_rej;
  logic sel_valid;
  logic [CREDIT_W-1:0] sel_price;
  logic cancel;
  logic err_price;
  logic disp_req;
  logic disp_ack;
  logic chg_req;
  logic [1:0] chg_coin;
  logic chg_ack;
  logic [CREDIT_W-1:0] credit;
  logic busy;
  modport slave (
    input coin_valid, coin, sel_valid, sel_price, cancel, disp_ack, chg_ack,
    output coin_ready, coin_rej, err_price, disp_req, chg_req, chg_coin, credit, busy
  );
  modport master (
    output coin_valid, coin, sel_valid, sel_price, cancel, disp_ack, chg_ack,
    input coin_ready, coin_rej, err_price, disp_req, chg_req, chg_coin, credit, busy
  );
endinterface

// File: rtl/vend_idle_timer.sv
// vend_idle_timer: idle counter that flags expiry after TIMEOUT_CYC enabled cycles.
module vend_idle_timer #(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);
  logic [CW-1:0] r_cnt;
  assign expire = enable && r_cnt == LAST;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cnt <= '0;
    else if (clear || !enable) r_cnt <= '0;
    else if (!expire) r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/vend_sequencer.sv
// vend_sequencer: credit accumulation, selection check, dispense and change sequencing.
// Idle auto-refund timer is built only when VEND_TIMEOUT_EN is defined.
module vend_sequencer
  import vend_pkg::*;
#(
  parameter int CREDIT_W = 4,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic   clk,
  input  logic   rst,
  vend_if.slave  bus
);
  localparam logic [CREDIT_W-1:0] LIMIT = CREDIT_W'((1 << CREDIT_W) - 3);
  localparam logic [CREDIT_W-1:0] ONE = CREDIT_W'(1);
  localparam logic [CREDIT_W-1:0] TWO = CREDIT_W'(2);
  vend_state_t r_state, w_next;
  logic [CREDIT_W-1:0] r_credit, w_credit, w_dec;
  logic r_gap, w_gap, r_rej, w_rej, r_err, w_err;
  logic w_ready, w_coin_acc, w_coin_ok, w_afford, w_expire;
  // LIMIT = MAX-2 keeps a 10 rs coin from wrapping the credit register
  assign w_ready = !rst && r_state == COLLECT && !bus.sel_valid && !bus.cancel && r_credit <= LIMIT;
  assign w_coin_acc = bus.coin_valid && w_ready;
  assign w_coin_ok = bus.coin == COIN_5 || bus.coin == COIN_10;
  assign w_afford = bus.sel_price != '0 && r_credit >= bus.sel_price;
  assign w_dec = r_credit >= TWO ? TWO : ONE;
`ifdef VEND_TIMEOUT_EN
  vend_idle_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (w_coin_acc || bus.sel_valid || bus.cancel),
    .enable (r_state == COLLECT && r_credit != '0),
    .expire (w_expire)
  );
`else
  logic w_unused_timeout;
  assign w_unused_timeout = TIMEOUT_CYC != 0;
  assign w_expire = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    w_credit = r_credit;
    w_gap = 1'b0;
    w_rej = 1'b0;
    w_err = 1'b0;
    case (r_state)
      COLLECT:
        if (bus.sel_valid) begin
          w_err = !w_afford;
          w_credit = w_afford ? r_credit - bus.sel_price : r_credit;
          w_next = w_afford ? VEND : COLLECT;
        end else if (bus.cancel) begin
          w_next = r_credit != '0 ? REFUND : COLLECT;
        end else if (w_coin_acc) begin
          w_rej = !w_coin_ok;
          w_credit = w_coin_ok ? r_credit + (bus.coin == COIN_10 ? TWO : ONE) : r_credit;
        end else if (w_expire) begin
          w_next = REFUND;
        end
      VEND:
        if (bus.disp_ack) w_next = r_credit != '0 ? REFUND : COLLECT;
      REFUND:
        // r_gap holds chg_req low for one cycle after each ejected coin
        if (bus.chg_ack && !r_gap) begin
          w_credit = r_credit - w_dec;
          w_next = r_credit == w_dec ? COLLECT : REFUND;
          w_gap = 1'b1;
        end
      default: w_next = COLLECT;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= COLLECT;
      r_credit <= '0;
      r_gap <= 1'b0;
      r_rej <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_next;
      r_credit <= w_credit;
      r_gap <= w_gap;
      r_rej <= w_rej;
      r_err <= w_err;
    end
  end
  assign bus.coin_ready = w_ready;
  assign bus.coin_rej = r_rej;
  assign bus.err_price = r_err;
  assign bus.disp_req = r_state == VEND;
  assign bus.chg_req = r_state == REFUND && !r_gap;
  assign bus.chg_coin = bus.chg_req ? (r_credit >= TWO ? COIN_10 : COIN_5) : 2'b00;
  assign bus.credit = r_credit;
  assign bus.busy = r_state != COLLECT;
endmodule

// File: tb/tb_vend_sequencer.sv
// tb_vend_sequencer: directed self-checking bench for vend_sequencer (CREDIT_W=4, TIMEOUT_CYC=8).
module tb_vend_sequencer;
  import vend_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int pass_cnt = 0;
  int total = 0;
  vend_if #(.CREDIT_W(4)) bus ();
  vend_sequencer #(.CREDIT_W(4), .TIMEOUT_CYC(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.coin_valid = 1'b0;
    bus.coin = 2'b00;
    bus.sel_valid = 1'b0;
    bus.sel_price = '0;
    bus.cancel = 1'b0;
    bus.disp_ack = 1'b0;
    bus.chg_ack = 1'b0;
  endtask

  task automatic put_coin(input logic [1:0] c);
    bus.coin_valid = 1'b1;
    bus.coin = c;
    tick();
    bus.coin_valid = 1'b0;
    bus.coin = 2'b00;
  endtask

  task automatic select(input logic [3:0] p);
    bus.sel_valid = 1'b1;
    bus.sel_price = p;
    tick();
    bus.sel_valid = 1'b0;
    bus.sel_price = '0;
  endtask

  task automatic test_reset();
    logic [12:0] obs;
    idle();
    rst = 1'b1;
    repeat (3) tick();
    obs = {bus.coin_ready, bus.coin_rej, bus.err_price, bus.disp_req, bus.chg_req,
           bus.chg_coin, bus.credit, bus.busy};
    total++;
    if (obs !== 13'd0) $display("FAIL reset_outputs got %b want 0", obs); else pass_cnt++;
    rst = 1'b0;
    #1;
    total++;
    if (bus.coin_ready !== 1'b1) $display("FAIL reset_release_ready got %b want 1", bus.coin_ready); else pass_cnt++;
  endtask

  task automatic test_exact();
    bit chg_seen = 0;
    put_coin(COIN_5);
    put_coin(COIN_10);
    total++;
    if (bus.credit !== 4'd3) $display("FAIL exact_credit got %0d want 3", bus.credit); else pass_cnt++;
    select(4'd3);
    total++;
    if ({bus.disp_req, bus.credit, bus.busy} !== {1'b1, 4'd0, 1'b1})
      $display("FAIL exact_vend disp=%b credit=%0d busy=%b want 1/0/1", bus.disp_req, bus.credit, bus.busy);
    else pass_cnt++;
    repeat (3) begin
      chg_seen |= bus.chg_req;
      tick();
    end
    bus.disp_ack = 1'b1;
    tick();
    bus.disp_ack = 1'b0;
    chg_seen |= bus.chg_req;
    total++;
    if ({bus.disp_req, bus.busy, chg_seen} !== 3'b000)
      $display("FAIL exact_done disp=%b busy=%b chg_seen=%b want 000", bus.disp_req, bus.busy, chg_seen);
    else pass_cnt++;
  endtask

  task automatic test_overpay();
    put_coin(COIN_10);
    put_coin(COIN_10);
    total++;
    if (bus.credit !== 4'd4) $display("FAIL over_credit got %0d want 4", bus.credit); else pass_cnt++;
    select(4'd3);
    total++;
    if ({bus.disp_req, bus.chg_req, bus.credit} !== {2'b10, 4'd1})
      $display("FAIL over_vend disp=%b chg=%b credit=%0d want 1/0/1", bus.disp_req, bus.chg_req, bus.credit);
    else pass_cnt++;
    tick();
    bus.disp_ack = 1'b1;
    tick();
    bus.disp_ack = 1'b0;
    total++;
    if ({bus.disp_req, bus.chg_req, bus.chg_coin} !== {2'b01, COIN_5})
      $display("FAIL over_change disp=%b chg=%b coin=%b want 0/1/01", bus.disp_req, bus.chg_req, bus.chg_coin);
    else pass_cnt++;
    bus.chg_ack = 1'b1;
    tick();
    bus.chg_ack = 1'b0;
    total++;
    if ({bus.chg_req, bus.credit, bus.busy} !== {1'b0, 4'd0, 1'b0})
      $display("FAIL over_end chg=%b credit=%0d busy=%b want 0/0/0", bus.chg_req, bus.credit, bus.busy);
    else pass_cnt++;
  endtask

  task automatic test_reject_cancel();
    put_coin(COIN_10);
    select(4'd3);
    total++;
    if ({bus.err_price, bus.credit, bus.busy} !== {1'b1, 4'd2, 1'b0})
      $display("FAIL rej_err err=%b credit=%0d busy=%b want 1/2/0", bus.err_price, bus.credit, bus.busy);
    else pass_cnt++;
    tick();
    total++;
    if (bus.err_price !== 1'b0) $display("FAIL rej_pulse got %b want 0", bus.err_price); else pass_cnt++;
    select(4'd0);
    total++;
    if ({bus.err_price, bus.credit} !== {1'b1, 4'd2})
      $display("FAIL rej_zero err=%b credit=%0d want 1/2", bus.err_price, bus.credit);
    else pass_cnt++;
    bus.cancel = 1'b1;
    bus.coin_valid = 1'b1;
    bus.coin = COIN_5;
    #1;
    total++;
    if (bus.coin_ready !== 1'b0) $display("FAIL cancel_ready got %b want 0", bus.coin_ready); else pass_cnt++;
    tick();
    idle();
    total++;
    if ({bus.chg_req, bus.chg_coin, bus.credit} !== {1'b1, COIN_10, 4'd2})
      $display("FAIL cancel_eject chg=%b coin=%b credit=%0d want 1/10/2", bus.chg_req, bus.chg_coin, bus.credit);
    else pass_cnt++;
    bus.chg_ack = 1'b1;
    tick();
    bus.chg_ack = 1'b0;
    tick();
    total++;
    if ({bus.chg_req, bus.credit, bus.busy} !== {1'b0, 4'd0, 1'b0})
      $display("FAIL cancel_end chg=%b credit=%0d busy=%b want 0/0/0", bus.chg_req, bus.credit, bus.busy);
    else pass_cnt++;
  endtask

  task automatic test_refund_mix();
    put_coin(COIN_10);
    put_coin(COIN_5);
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    total++;
    if ({bus.chg_req, bus.chg_coin} !== {1'b1, COIN_10})
      $display("FAIL mix_first chg=%b coin=%b want 1/10", bus.chg_req, bus.chg_coin);
    else pass_cnt++;
    bus.chg_ack = 1'b1;
    tick();
    bus.chg_ack = 1'b0;
    total++;
    if ({bus.chg_req, bus.credit, bus.busy} !== {1'b0, 4'd1, 1'b1})
      $display("FAIL mix_gap chg=%b credit=%0d busy=%b want 0/1/1", bus.chg_req, bus.credit, bus.busy);
    else pass_cnt++;
    tick();
    total++;
    if ({bus.chg_req, bus.chg_coin} !== {1'b1, COIN_5})
      $display("FAIL mix_second chg=%b coin=%b want 1/01", bus.chg_req, bus.chg_coin);
    else pass_cnt++;
    bus.chg_ack = 1'b1;
    tick();
    bus.chg_ack = 1'b0;
    total++;
    if ({bus.credit, bus.busy} !== {4'd0, 1'b0})
      $display("FAIL mix_end credit=%0d busy=%b want 0/0", bus.credit, bus.busy);
    else pass_cnt++;
  endtask

  task automatic test_full_invalid();
    repeat (7) put_coin(COIN_10);
    total++;
    if ({bus.credit, bus.coin_ready} !== {4'd14, 1'b0})
      $display("FAIL full_ready credit=%0d ready=%b want 14/0", bus.credit, bus.coin_ready);
    else pass_cnt++;
    put_coin(COIN_10);
    bus.disp_ack = 1'b1;
    bus.chg_ack = 1'b1;
    tick();
    idle();
    total++;
    if ({bus.credit, bus.busy, bus.coin_rej} !== {4'd14, 2'b00})
      $display("FAIL full_ignore credit=%0d busy=%b rej=%b want 14/0/0", bus.credit, bus.busy, bus.coin_rej);
    else pass_cnt++;
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    for (int i = 0; i < 7; i++) begin
      total++;
      if ({bus.chg_req, bus.chg_coin} !== {1'b1, COIN_10})
        $display("FAIL full_eject%0d chg=%b coin=%b want 1/10", i, bus.chg_req, bus.chg_coin);
      else pass_cnt++;
      bus.chg_ack = 1'b1;
      tick();
      bus.chg_ack = 1'b0;
      total++;
      if (bus.credit !== 4'(12 - 2 * i))
        $display("FAIL full_credit%0d got %0d want %0d", i, bus.credit, 12 - 2 * i);
      else pass_cnt++;
      if (i < 6) tick();
    end
    total++;
    if (bus.busy !== 1'b0) $display("FAIL full_end busy got %b want 0", bus.busy); else pass_cnt++;
    put_coin(2'b11);
    total++;
    if ({bus.coin_rej, bus.credit} !== {1'b1, 4'd0})
      $display("FAIL invalid_rej rej=%b credit=%0d want 1/0", bus.coin_rej, bus.credit);
    else pass_cnt++;
    tick();
    total++;
    if (bus.coin_rej !== 1'b0) $display("FAIL invalid_pulse got %b want 0", bus.coin_rej); else pass_cnt++;
  endtask

  task automatic test_timeout();
    bit early = 0;
    put_coin(COIN_5);
`ifdef VEND_TIMEOUT_EN
    repeat (7) begin
      tick();
      early |= bus.chg_req;
    end
    tick();
    total++;
    if ({early, bus.chg_req, bus.chg_coin} !== {2'b01, COIN_5})
      $display("FAIL timeout_refund early=%b chg=%b coin=%b want 0/1/01", early, bus.chg_req, bus.chg_coin);
    else pass_cnt++;
    bus.chg_ack = 1'b1;
    tick();
    bus.chg_ack = 1'b0;
`else
    repeat (100) begin
      tick();
      early |= bus.chg_req | bus.busy;
    end
    total++;
    if ({early, bus.credit} !== {1'b0, 4'd1})
      $display("FAIL no_timeout busy_seen=%b credit=%0d want 0/1", early, bus.credit);
    else pass_cnt++;
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    bus.chg_ack = 1'b1;
    tick();
    bus.chg_ack = 1'b0;
`endif
    total++;
    if ({bus.credit, bus.busy} !== {4'd0, 1'b0})
      $display("FAIL timeout_end credit=%0d busy=%b want 0/0", bus.credit, bus.busy);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_vend();
    put_coin(COIN_10);
    put_coin(COIN_10);
    select(4'd2);
    total++;
    if (bus.disp_req !== 1'b1) $display("FAIL midrst_vend got %b want 1", bus.disp_req); else pass_cnt++;
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({bus.disp_req, bus.credit, bus.busy, bus.coin_ready} !== {1'b0, 4'd0, 2'b00})
      $display("FAIL midrst_abort disp=%b credit=%0d busy=%b ready=%b want 0/0/0/0",
               bus.disp_req, bus.credit, bus.busy, bus.coin_ready);
    else pass_cnt++;
    tick();
    rst = 1'b0;
    tick();
    total++;
    if ({bus.coin_ready, bus.credit} !== {1'b1, 4'd0})
      $display("FAIL midrst_release ready=%b credit=%0d want 1/0", bus.coin_ready, bus.credit);
    else pass_cnt++;
  endtask

  initial begin
    idle();
    test_reset();
    test_exact();
    test_overpay();
    test_reject_cancel();
    test_refund_mix();
    test_full_invalid();
    test_timeout();
    test_reset_mid_vend();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/vend_sequencer.md
# vend_sequencer

Credit and dispense sequencer for the coin-operated vending path. Accepts 5 rs / 10 rs coin events from the coin acceptor, accumulates credit in 5 rs units, checks product selections against credit, and sequences the dispense mechanism and change ejector through req/ack handshakes. It sits between the coin/keypad front end and the motor and ejector drivers, and is the single owner of the credit register.

## Interface
- `CREDIT_W`, default 4: credit width in 5 rs units; MAX = 2^CREDIT_W - 1.
- `TIMEOUT_CYC`, default 1000: idle cycles before auto-refund (only with `VEND_TIMEOUT_EN`).
- `clk` in, 1: single clock, rising edge.
- `rst` in, 1: asynchronous, active-high reset.
- `coin_valid` in, 1: coin event present.
- `coin` in, 2: coin code. 01 = 5 rs, 10 = 10 rs, 00/11 invalid.
- `coin_ready` out, 1: sequencer can accept a coin this cycle.
- `coin_rej` out, 1: one-cycle pulse when an invalid coin code is presented while ready.
- `sel_valid` in, 1: product selection strobe.
- `sel_price` in, CREDIT_W: price of the selected product, in 5 rs units.
- `cancel` in, 1: user refund request.
- `err_price` out, 1: one-cycle pulse when a selection is rejected.
- `disp_req` out, 1: dispense request to the motor driver.
- `disp_ack` in, 1: dispense done, single-cycle pulse.
- `chg_req` out, 1: change coin request to the ejector.
- `chg_coin` out, 2: coin to eject. 01 = 5 rs, 10 = 10 rs. Stable while `chg_req` is high.
- `chg_ack` in, 1: coin ejected, single-cycle pulse.
- `credit` out, CREDIT_W: current credit.
- `busy` out, 1: high in any state other than COLLECT.

## Operation
- States: COLLECT, VEND, REFUND. Reset state is COLLECT.
- Reset values: all outputs 0, credit 0, timer 0. Asserting `rst` mid-operation aborts immediately and drops credit.
- **COLLECT, ready:** `coin_ready` = COLLECT && !`sel_valid` && !`cancel` && credit ≤ MAX-2.
- **COLLECT, coin accept:** when `coin_valid` && `coin_ready`:
  - code 01 adds 1 to credit; code 10 adds 2.
  - an invalid code leaves credit unchanged and pulses `coin_rej`.
- **COLLECT, selection:** selection has priority over cancel; a coin is never accepted in the same cycle as `sel_valid` or `cancel`.
  - If `sel_valid` && `sel_price` ≠ 0 && credit ≥ `sel_price`: credit ← credit - `sel_price`, go to VEND.
  - Otherwise (`sel_price` = 0 or insufficient credit): pulse `err_price`, stay in COLLECT, credit unchanged.
- **COLLECT, cancel:** `cancel` with credit > 0 goes to REFUND; with credit = 0 it is ignored.
- **VEND:** `disp_req` is held high until `disp_ack` is sampled. Then go to REFUND if credit > 0, else COLLECT.
- **REFUND:**
  - `chg_coin` = 10 if credit ≥ 2, else 01.
  - On `chg_ack`, credit decreases by 2 or 1 to match `chg_coin`.
  - On reaching 0, return to COLLECT.
- Acks received outside their own state (`disp_ack` outside VEND, `chg_ack` outside REFUND) are ignored.
- Credit never wraps. The `coin_ready` guard guarantees credit ≤ MAX.

## Timing
- Coin accepted at cycle N: `credit` updated at N+1.
- Selection accepted at N: `disp_req` = 1 and reduced `credit` visible at N+1. `err_price` pulses at N+1.
- `disp_ack` at N: `disp_req` = 0 at N+1. `chg_req` = 1 at N+1 if residual credit remains.
- `cancel` accepted at N: `chg_req` = 1 at N+1.
- `chg_ack` at N:
  - at N+1: `chg_req` = 0 and credit updated;
  - at N+2: `chg_req` re-asserts with the new `chg_coin` if credit > 0, else the state is COLLECT.
- `disp_req` and `chg_req` are never high simultaneously.

## Configuration
- `VEND_TIMEOUT_EN` defined:
  - An idle timer runs in COLLECT while credit > 0.
  - It clears on any accepted coin, any `sel_valid`, and any `cancel`.
  - When it reaches TIMEOUT_CYC-1, the next cycle enters REFUND.
- `VEND_TIMEOUT_EN` undefined: no timer logic is built; credit is held indefinitely.

## Structure
- Package `vend_pkg` holds:
  - the state enum `vend_state_t`;
  - coin code constants `COIN_5`=2'b01 and `COIN_10`=2'b10.
- Sub-module `vend_idle_timer` holds the timeout counter, with inputs clear/enable, output `expire`, and parameter TIMEOUT_CYC. It is instantiated only under `VEND_TIMEOUT_EN`.

## Test plan
- Reset check: hold `rst` high 3 cycles → all outputs 0, `busy` = 0; release → `coin_ready` = 1.
- Exact payment: coin 01, then coin 10 (credit 3); `sel_price` = 3 → `disp_req` = 1 next cycle, `credit` = 0; `disp_ack` 4 cycles later → COLLECT, `chg_req` never asserted.
- Overpayment: coins 10, 10 (credit 4); `sel_price` = 3 → dispense; after `disp_ack`, `chg_req` = 1 with `chg_coin` = 01; `chg_ack` → `credit` = 0, COLLECT.
- Rejected selection and cancel: credit 2, `sel_price` = 3 → `err_price` one cycle, `credit` = 2; `cancel` → one `chg_coin` = 10 eject, then COLLECT.
- Full credit and invalid coin: credit 14 with `CREDIT_W` = 4 → `coin_ready` = 0, `coin_valid` 10 ignored; at credit 0, code 11 → `coin_rej` pulse, credit 0.
- Timeout and mid-vend reset: with `TIMEOUT_CYC` = 8, credit 1, idle → `chg_req` at cycle 9; without the macro, no `chg_req` after 100 cycles. `rst` during VEND → `disp_req` = 0 immediately.
